sram_responder: RTL and testbench

- Synthesizable stand-in for the external 8-bit asynchronous SRAM: the device end of the ce/we/oe pin protocol that the team's SRAM controller drives.
- Backed by an on-chip byte array, so controller-side logic can run on-chip and in simulation without the board part.
- Also decodes the controller's two-beat write (low byte at A, high byte at A+1 on the next cycle) into a 16-bit word event.
- Flags protocol violations.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_resp_mem.sv | 40 ++++
 rtl/sram_responder.sv | 151 +++++++++++++++
 tb/tb_sram_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder slice.
//
// Contents:
//   num           - signed 16-bit word type used for decoded two-beat writes
//   SRAM_ADDR_W   - width of the external byte address bus (21)
//   SRAM_DATA_W   - width of the external data bus (8)
//   word_state_t  - states of the two-beat write decoder
package sram_pkg;

  localparam int SRAM_ADDR_W = 21;
  localparam int SRAM_DATA_W = 8;

  typedef logic signed [15:0] num;

  typedef enum logic {
    IDLE,
    LO_HELD
  } word_state_t;

endpackage

// File: rtl/sram_resp_mem.sv
// Byte array backing the SRAM responder.
//
// Ports:
//   clk        - system clock (write port)
//   wr_en      - write strobe, sampled on posedge clk
//   wr_addr    - write byte address
//   wr_data    - write byte
//   rd_addr    - device-side asynchronous read address
//   rd_data    - device-side asynchronous read data
//   host_addr  - backdoor asynchronous read address
//   host_rdata - backdoor asynchronous read data
//
// Contents are deliberately not reset, matching the external part.
module sram_resp_mem
  import sram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [SRAM_DATA_W-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [SRAM_DATA_W-1:0] rd_data,
  input  logic [AW-1:0]          host_addr,
  output logic [SRAM_DATA_W-1:0] host_rdata
);

  logic [SRAM_DATA_W-1:0] mem_array [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[wr_addr] <= wr_data;
    end
  end

  assign rd_data    = mem_array[rd_addr];
  assign host_rdata = mem_array[host_addr];

endmodule

// File: rtl/sram_responder.sv
// Synthesizable stand-in for an external 8-bit asynchronous SRAM. Answers the
// ce/we/oe pin protocol from an on-chip byte array, decodes two-beat writes
// (low byte at A, high byte at A+1 on the next cycle) into word events, and
// flags out-of-range accesses and ce/we/oe protocol violations.
//
// Optional build macro: SRAM_RESPONDER_STATS_EN enables saturating read/write
// byte counters; without it rd_count/wr_count are tied to zero.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-low reset
//   sram_data  - device data bus (driven only during a clean read)
//   sram_addr  - byte address
//   sram_ce    - chip enable, active-low
//   sram_we    - write enable, active-low
//   sram_oe    - output enable, active-low
//   word_valid - one-cycle pulse after a completed two-beat write
//   word_addr  - low-byte address of the last completed word
//   word_data  - last completed word, {hi, lo}
//   oor_err    - sticky: access above the implemented address range
//   proto_err  - sticky: ce, we and oe all asserted together
//   host_addr  - backdoor read address
//   host_rdata - backdoor read data (combinational)
//   rd_count   - byte read counter (stats build only)
//   wr_count   - byte write counter (stats build only)
module sram_responder
  import sram_pkg::*;
#(
  parameter int                     MEM_AW   = 10,
  parameter logic [SRAM_DATA_W-1:0] OOR_DATA = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [SRAM_DATA_W-1:0] sram_data,
  input  logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic                   sram_ce,
  input  logic                   sram_we,
  input  logic                   sram_oe,
  output logic                   word_valid,
  output logic [SRAM_ADDR_W-1:0] word_addr,
  output num                     word_data,
  output logic                   oor_err,
  output logic                   proto_err,
  input  logic [MEM_AW-1:0]      host_addr,
  output logic [SRAM_DATA_W-1:0] host_rdata,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
);

  logic                   dev_read;
  logic                   write_beat;
  logic                   in_range;
  logic                   violation;
  logic [SRAM_DATA_W-1:0] mem_rdata;

  word_state_t            state;
  logic [SRAM_DATA_W-1:0] lo_byte;
  logic [SRAM_ADDR_W-1:0] base_addr;

  // A write beat wins over a read when we and oe are both asserted, so the
  // bus is only driven for a clean read.
  assign dev_read   = !sram_ce && !sram_oe && sram_we;
  assign write_beat = !sram_ce && !sram_we;
  assign violation  = !sram_ce && !sram_we && !sram_oe;
  assign in_range   = (sram_addr[SRAM_ADDR_W-1:MEM_AW] == '0);

  assign sram_data = dev_read ? (in_range ? mem_rdata : OOR_DATA) : 'z;

  sram_resp_mem #(
    .AW (MEM_AW)
  ) u_mem (
    .clk        (clk),
    .wr_en      (write_beat && in_range),
    .wr_addr    (sram_addr[MEM_AW-1:0]),
    .wr_data    (sram_data),
    .rd_addr    (sram_addr[MEM_AW-1:0]),
    .rd_data    (mem_rdata),
    .host_addr  (host_addr),
    .host_rdata (host_rdata)
  );

  // Word decoder and sticky error flags. The high beat must arrive on the
  // very next cycle at base+1; any other write restarts the pair with itself
  // as the new low byte, and a non-write cycle abandons the pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lo_byte    <= '0;
      base_addr  <= '0;
      word_valid <= 1'b0;
      word_addr  <= '0;
      word_data  <= '0;
      oor_err    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if ((dev_read || write_beat) && !in_range) begin
        oor_err <= 1'b1;
      end
      if (violation) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (write_beat) begin
            state     <= LO_HELD;
            lo_byte   <= sram_data;
            base_addr <= sram_addr;
          end
        end
        LO_HELD: begin
          if (write_beat) begin
            if (sram_addr == base_addr + SRAM_ADDR_W'(1)) begin
              state      <= IDLE;
              word_valid <= 1'b1;
              word_addr  <= base_addr;
              word_data  <= {sram_data, lo_byte};
            end else begin
              lo_byte   <= sram_data;
              base_addr <= sram_addr;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_RESPONDER_STATS_EN
  // Saturating access counters; out-of-range accesses are included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (dev_read && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (write_beat && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed pin-level cycles with a
// word-event scoreboard drained by an independent monitor.
module tb_sram_responder;
  import sram_pkg::*;

  logic        clk;
  logic        reset;
  wire  [7:0]  sram_data;
  logic [20:0] sram_addr;
  logic        sram_ce;
  logic        sram_we;
  logic        sram_oe;
  logic        word_valid;
  logic [20:0] word_addr;
  num          word_data;
  logic        oor_err;
  logic        proto_err;
  logic [9:0]  host_addr;
  logic [7:0]  host_rdata;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  logic        tb_drive;
  logic [7:0]  tb_data;

  int total;
  int bad;
  int exp_rd;
  int exp_wr;

  typedef struct {
    logic [20:0] addr;
    logic [15:0] data;
  } word_t;

  word_t exp_q[$];

  assign sram_data = tb_drive ? tb_data : 'z;

  sram_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sram_data  (sram_data),
    .sram_addr  (sram_addr),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .word_valid (word_valid),
    .word_addr  (word_addr),
    .word_data  (word_data),
    .oor_err    (oor_err),
    .proto_err  (proto_err),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs change just after posedge and are held until the
  // next call; returns at negedge so combinational outputs can be checked.
  task automatic applyStimulus(input logic ce, input logic we, input logic oe,
                               input logic [20:0] addr, input logic drv,
                               input logic [7:0] d);
    @(posedge clk);
    #1;
    sram_ce   = ce;
    sram_we   = we;
    sram_oe   = oe;
    sram_addr = addr;
    tb_drive  = drv;
    tb_data   = d;
    if (!ce && !oe && we) exp_rd++;
    if (!ce && !we) exp_wr++;
    @(negedge clk);
  endtask

  task automatic writeBeat(input logic [20:0] addr, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, 1'b1, d);
  endtask

  task automatic readBeat(input logic [20:0] addr);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, 1'b0, 8'h00);
  endtask

  task automatic idleBeat();
    applyStimulus(1'b1, 1'b1, 1'b1, 21'h0, 1'b0, 8'h00);
  endtask

  task automatic pushWord(input logic [20:0] addr, input logic [15:0] d);
    word_t w;
    w.addr = addr;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic checkHost(input string name, input logic [9:0] a,
                           input logic [7:0] exp);
    host_addr = a;
    #1;
    checkOutput(name, {24'h0, host_rdata}, {24'h0, exp});
  endtask

  // Monitor: every word pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && word_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_word", {11'h0, word_addr}, 32'h0);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        checkOutput("word_addr", {11'h0, word_addr}, {11'h0, w.addr});
        checkOutput("word_data", {16'h0, word_data}, {16'h0, w.data});
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    exp_rd    = 0;
    exp_wr    = 0;
    reset     = 1'b0;
    sram_ce   = 1'b1;
    sram_we   = 1'b1;
    sram_oe   = 1'b1;
    sram_addr = '0;
    tb_drive  = 1'b0;
    tb_data   = '0;
    host_addr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_word_valid", {31'h0, word_valid}, 32'h0);
    checkOutput("rst_word_addr", {11'h0, word_addr}, 32'h0);
    checkOutput("rst_word_data", {16'h0, word_data}, 32'h0);
    checkOutput("rst_oor_err", {31'h0, oor_err}, 32'h0);
    checkOutput("rst_proto_err", {31'h0, proto_err}, 32'h0);
    checkOutput("rst_rd_count", {16'h0, rd_count}, 32'h0);
    checkOutput("rst_wr_count", {16'h0, wr_count}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] two-beat write 1234 at 0x010");
    pushWord(21'h010, 16'h1234);
    writeBeat(21'h010, 8'h34);
    writeBeat(21'h011, 8'h12);
    idleBeat();
    checkHost("mem_010", 10'h010, 8'h34);
    checkHost("mem_011", 10'h011, 8'h12);

    $display("[TB] read back and bus release");
    readBeat(21'h010);
    checkOutput("rd_010", {24'h0, sram_data}, 32'h34);
    readBeat(21'h011);
    checkOutput("rd_011", {24'h0, sram_data}, 32'h12);
    applyStimulus(1'b0, 1'b1, 1'b1, 21'h010, 1'b1, 8'h00);
    checkOutput("release_oe_high", {24'h0, sram_data}, 32'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 21'h011, 1'b1, 8'h00);
    checkOutput("release_ce_high", {24'h0, sram_data}, 32'h00);

    $display("[TB] restarted pair 0x020, 0x030, 0x031");
    writeBeat(21'h020, 8'h55);
    pushWord(21'h030, 16'h5678);
    writeBeat(21'h030, 8'h78);
    writeBeat(21'h031, 8'h56);
    idleBeat();
    checkHost("mem_020", 10'h020, 8'h55);
    checkHost("mem_030", 10'h030, 8'h78);

    $display("[TB] out-of-range access");
    writeBeat(21'h000, 8'h11);
    idleBeat();
    checkOutput("oor_before", {31'h0, oor_err}, 32'h0);
    readBeat(21'h100000);
    checkOutput("rd_oor", {24'h0, sram_data}, 32'hFF);
    writeBeat(21'h100000, 8'h99);
    idleBeat();
    checkOutput("oor_set", {31'h0, oor_err}, 32'h1);
    checkHost("mem_000_kept", 10'h000, 8'h11);

    $display("[TB] word straddling the top of memory");
    pushWord(21'h3FF, 16'hCDAB);
    writeBeat(21'h3FF, 8'hAB);
    writeBeat(21'h400, 8'hCD);
    idleBeat();
    idleBeat();
    checkHost("mem_3ff", 10'h3FF, 8'hAB);
    checkHost("mem_000_wrap", 10'h000, 8'h11);
    checkOutput("oor_held", {31'h0, oor_err}, 32'h1);
    checkOutput("proto_before", {31'h0, proto_err}, 32'h0);

    $display("[TB] protocol violation, then reset mid-pair");
    writeBeat(21'h040, 8'h77);
    idleBeat();
    applyStimulus(1'b0, 1'b0, 1'b0, 21'h040, 1'b1, 8'h00);
    checkOutput("proto_bus", {24'h0, sram_data}, 32'h00);
    @(posedge clk);
    #1;
    checkOutput("proto_set", {31'h0, proto_err}, 32'h1);
    checkHost("mem_040_proto", 10'h040, 8'h00);
    reset    = 1'b0;
    sram_ce  = 1'b1;
    sram_we  = 1'b1;
    sram_oe  = 1'b1;
    tb_drive = 1'b0;
    exp_rd   = 0;
    exp_wr   = 0;
    #1;
    checkOutput("midrst_proto", {31'h0, proto_err}, 32'h0);
    checkOutput("midrst_oor", {31'h0, oor_err}, 32'h0);
    checkOutput("midrst_word_addr", {11'h0, word_addr}, 32'h0);
    checkOutput("midrst_word_data", {16'h0, word_data}, 32'h0);
    checkOutput("midrst_counts", {rd_count, wr_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    writeBeat(21'h041, 8'h22);
    idleBeat();
    checkHost("mem_041", 10'h041, 8'h22);

    $display("[TB] access counters");
    pushWord(21'h050, 16'h4433);
    writeBeat(21'h050, 8'h33);
    writeBeat(21'h051, 8'h44);
    readBeat(21'h050);
    checkOutput("rd_050", {24'h0, sram_data}, 32'h33);
    readBeat(21'h051);
    checkOutput("rd_051", {24'h0, sram_data}, 32'h44);
    idleBeat();
`ifdef SRAM_RESPONDER_STATS_EN
    checkOutput("rd_count", {16'h0, rd_count}, exp_rd);
    checkOutput("wr_count", {16'h0, wr_count}, exp_wr);
`else
    checkOutput("rd_count", {16'h0, rd_count}, 32'h0);
    checkOutput("wr_count", {16'h0, wr_count}, 32'h0);
`endif

    repeat (3) idleBeat();
    checkOutput("words_pending", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
